// File: rtl/switch_reader_pkg.sv
// switch_reader_pkg: shared I/O constants and register word selects for the switch peripheral
package switch_reader_pkg;
    localparam logic [31:0] IO_LED_ADDR = 32'h0000_FF00;
    localparam logic [31:0] IO_SWITCH_ADDR = 32'h0000_FF10;
    typedef enum logic [1:0] {
        REG_LEVEL = 2'd0,
        REG_FLAGS = 2'd1,
        REG_MASK  = 2'd2,
        REG_RSVD  = 2'd3
    } reg_sel_e;
endpackage

// File: rtl/switch_reader_debounce_cell.sv
// debounce_cell: 2-flop synchronizer plus stability counter producing one accepted level
module debounce_cell #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    logic meta, sync, expire;
    logic [CW-1:0] cnt;
    // rise is the combinational look-ahead of level going 0->1 on this edge
    assign expire = (sync != level) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
    assign rise = expire && sync;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta  <= 1'b0;
            sync  <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
        end else begin
            meta <= raw;
            sync <= meta;
            if (sync == level) cnt <= '0;
            else if (expire) begin
                level <= sync;
                cnt   <= '0;
            end else cnt <= cnt + CW'(1);
        end
    end
endmodule

// File: rtl/switch_reader.sv
// switch_reader: debounced switch inputs with sticky rising-edge flags, mask and irq on the data bus
module switch_reader
    import switch_reader_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw_in,
    input  logic             MemRead,
    input  logic             MemWrite,
    input  logic [1:0]       Address,
    input  logic [31:0]      Write_data,
    output logic [31:0]      Read_data,
    output logic             irq
);
    logic [WIDTH-1:0] level, rise, flags, mask, clr, flags_next, mask_next, rd_val;
    reg_sel_e sel;
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cell (
            .clk(clk), .reset(reset), .raw(raw_in[i]), .level(level[i]), .rise(rise[i])
        );
    end
    assign sel = reg_sel_e'(Address);
    // a new edge is ORed in after clearing so a simultaneous set always survives
    always_comb begin
        clr = ((MemRead && sel == REG_FLAGS) ? flags : '0)
            | ((MemWrite && sel == REG_FLAGS) ? Write_data[WIDTH-1:0] : '0);
        flags_next = (flags & ~clr) | rise;
        mask_next = (MemWrite && sel == REG_MASK) ? Write_data[WIDTH-1:0] : mask;
        rd_val = sel == REG_LEVEL ? level : sel == REG_FLAGS ? flags : sel == REG_MASK ? mask : '0;
        Read_data = MemRead ? 32'(rd_val) : 32'd0;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags <= '0;
            mask  <= '0;
            irq   <= 1'b0;
        end else begin
            flags <= flags_next;
            mask  <= mask_next;
            irq   <= |(flags_next & mask_next);
        end
    end
endmodule

// File: tb/tb_switch_reader.sv
// tb_switch_reader: directed plus random stimulus checked against a sliding-window reference model
module tb_switch_reader;
    localparam int W = 8;
    localparam int D = 16;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [W-1:0] raw_in = '0;
    logic MemRead = 1'b0, MemWrite = 1'b0;
    logic [1:0] Address = 2'd0;
    logic [31:0] Write_data = '0;
    logic [31:0] Read_data;
    logic irq;
    int checks = 0, errors = 0;

    switch_reader #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) u_dut (
        .clk(clk), .reset(reset), .raw_in(raw_in), .MemRead(MemRead), .MemWrite(MemWrite),
        .Address(Address), .Write_data(Write_data), .Read_data(Read_data), .irq(irq)
    );

    always #5 clk = ~clk;

    // model: h[0] is raw seen at the previous edge; h[1..D] are the synchronized samples
    // the DUT has evaluated over the last D edges. A bit flips once all D differ from its level.
    logic [W-1:0] h [0:D];
    logic [W-1:0] m_lvl = '0, m_flags = '0, m_mask = '0, m_flip, m_clr;
    logic m_irq = 1'b0;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_lvl = '0;
            m_flags = '0;
            m_mask = '0;
            m_irq = 1'b0;
            for (int k = 0; k <= D; k++) h[k] = '0;
        end else begin
            m_flip = '1;
            for (int k = 1; k <= D; k++) m_flip &= h[k] ^ m_lvl;
            m_clr = '0;
            if (Address == 2'd1 && MemRead) m_clr |= m_flags;
            if (Address == 2'd1 && MemWrite) m_clr |= Write_data[W-1:0];
            m_flags = (m_flags & ~m_clr) | (m_flip & ~m_lvl);
            if (Address == 2'd2 && MemWrite) m_mask = Write_data[W-1:0];
            m_irq = |(m_flags & m_mask);
            m_lvl ^= m_flip;
            for (int k = D; k > 0; k--) h[k] = h[k-1];
            h[0] = raw_in;
        end
    end

    logic [31:0] exp_rd;
    always @(negedge clk) begin
        exp_rd = !MemRead ? 32'd0 : Address == 2'd0 ? {24'd0, m_lvl} :
                 Address == 2'd1 ? {24'd0, m_flags} : Address == 2'd2 ? {24'd0, m_mask} : 32'd0;
        checks++;
        if (Read_data !== exp_rd) begin
            errors++;
            $display("FAIL model_read t=%0t addr=%0d got %h expected %h", $time, Address, Read_data, exp_rd);
        end
        checks++;
        if (irq !== m_irq) begin
            errors++;
            $display("FAIL model_irq t=%0t got %b expected %b", $time, irq, m_irq);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic peek(input logic [1:0] a, input logic [31:0] exp, input string nm);
        MemRead = 1'b1;
        Address = a;
        #1;
        chk(nm, Read_data, exp);
        MemRead = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        MemWrite = 1'b1;
        Address = a;
        Write_data = d;
        tick();
        MemWrite = 1'b0;
    endtask

    task automatic do_reset(input logic [W-1:0] r);
        raw_in = r;
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    initial begin
        raw_in = 8'hFF;
        tick(2);
        peek(2'd0, 32'd0, "rst_level");
        peek(2'd1, 32'd0, "rst_flags");
        tick();
        peek(2'd2, 32'd0, "rst_mask");
        peek(2'd3, 32'd0, "rst_rsvd");
        chk("rst_irq", {31'd0, irq}, 32'd0);
        reset = 1'b0;
        tick(17);
        peek(2'd0, 32'h00, "pwr_level_e17");
        tick();
        peek(2'd0, 32'hFF, "pwr_level_e18");
        peek(2'd1, 32'hFF, "pwr_flags_e18");

        do_reset(8'h00);
        tick(20);
        raw_in[0] = 1'b1;
        tick(10);
        raw_in[0] = 1'b0;
        tick(30);
        peek(2'd0, 32'h00, "glitch_level");
        peek(2'd1, 32'h00, "glitch_flags");

        wr(2'd2, 32'h01);
        raw_in = 8'h01;
        tick(17);
        peek(2'd0, 32'h00, "lat_level_e17");
        chk("lat_irq_e17", {31'd0, irq}, 32'd0);
        tick();
        peek(2'd0, 32'h01, "lat_level_e18");
        peek(2'd1, 32'h01, "lat_flags_e18");
        chk("lat_irq_e18", {31'd0, irq}, 32'd1);
        MemRead = 1'b1;
        Address = 2'd1;
        #1 chk("rdclr_first", Read_data, 32'h01);
        tick();
        chk("rdclr_second", Read_data, 32'h00);
        chk("rdclr_irq", {31'd0, irq}, 32'd0);
        MemRead = 1'b0;

        raw_in = 8'h07;
        tick(20);
        peek(2'd1, 32'h06, "w1c_pre");
        wr(2'd1, 32'h02);
        peek(2'd1, 32'h04, "w1c_post");
        raw_in[3] = 1'b1;
        tick(20);
        wr(2'd1, 32'h08);
        raw_in[3] = 1'b0;
        tick(20);
        peek(2'd1, 32'h04, "fall_no_flag");
        raw_in[3] = 1'b1;
        tick(20);
        peek(2'd1, 32'h0C, "w1c_repress");

        wr(2'd1, 32'h04);
        raw_in[2] = 1'b0;
        tick(20);
        raw_in[2] = 1'b1;
        tick(17);
        MemRead = 1'b1;
        Address = 2'd1;
        #1 chk("setwin_read", Read_data, 32'h08);
        tick();
        chk("setwin_after", Read_data, 32'h04);
        MemRead = 1'b0;

        raw_in[5] = 1'b1;
        tick(12);
        reset = 1'b1;
        tick(2);
        peek(2'd0, 32'h00, "midrst_level");
        reset = 1'b0;
        tick(17);
        peek(2'd0, 32'h00, "midrst_e17");
        tick();
        peek(2'd0, {24'd0, raw_in}, "midrst_e18");
        peek(2'd1, {24'd0, raw_in}, "midrst_flags");

        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < W; i++) if ($urandom_range(0, 39) == 0) raw_in[i] = ~raw_in[i];
            MemRead = $urandom_range(0, 3) == 0;
            MemWrite = $urandom_range(0, 5) == 0;
            Address = 2'($urandom_range(0, 3));
            Write_data = $urandom;
            if (c == 1500) reset = 1'b1;
            if (c == 1503) reset = 1'b0;
            tick();
        end
        MemRead = 1'b0;
        MemWrite = 1'b0;
        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
